// File: rtl/clks_alot_edge_monitor_pkg.sv
// Shared types for the clks_alot clock-recovery front end.
//   clock_events_s : {rise, fall, any_edge} one-cycle event pulses
//                    ("edge" is a reserved word, hence any_edge)
//   clock_status_s : {locked (level), glitch (pulse), timeout (pulse)}
//   edge_mon_state_e : acquire/lock state machine encoding
package clks_alot_p;

    typedef struct packed {
        logic rise;
        logic fall;
        logic any_edge;
    } clock_events_s;

    typedef struct packed {
        logic locked;
        logic glitch;
        logic timeout;
    } clock_status_s;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } edge_mon_state_e;

endpackage

// File: rtl/clks_alot_edge_monitor_sync.sv
// N-flop synchroniser with asynchronous active-high reset.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset (flops clear to 0)
//   d_i   : asynchronous input
//   q_o   : synchronised output (last stage)
module clks_alot_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clks_alot_edge_monitor.sv
// Edge monitor: synchronises sig_i into the system domain, emits rise/fall
// events, measures high/low half-periods and runs an acquire/lock FSM.
//   sys_clk_i, sys_rst_i   : system clock, async active-high reset
//   enable_i               : monitor enable (low forces DISABLED)
//   sig_i                  : asynchronous monitored signal
//   min_half_i, max_half_i : legal half-period window, in cycles
//   events_o               : {rise, fall, any_edge} pulses
//   status_o               : {locked, glitch, timeout}
//   high_cycles_o          : last measured high half-period
//   low_cycles_o           : last measured low half-period
//   period_o               : high_cycles_o + low_cycles_o
//   period_valid_o         : pulse on a rise captured while locked / causing lock
module clks_alot_edge_monitor
    import clks_alot_p::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOCK_EDGES  = 4
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic             enable_i,
    input  logic             sig_i,
    input  logic [CNT_W-1:0] min_half_i,
    input  logic [CNT_W-1:0] max_half_i,
    output clock_events_s    events_o,
    output clock_status_s    status_o,
    output logic [CNT_W-1:0] high_cycles_o,
    output logic [CNT_W-1:0] low_cycles_o,
    output logic [CNT_W:0]   period_o,
    output logic             period_valid_o
);

    localparam int unsigned GOOD_W = $clog2(LOCK_EDGES + 1);

    edge_mon_state_e  state_q, state_d;
    logic             s, s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic             primed_q, primed_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W:0]   period_q, period_d;
    logic             valid_q, valid_d;
    logic             glitch_q, glitch_d;
    logic             timeout_q, timeout_d;
    clock_events_s    events_q, events_d;

    logic rise, fall, edge_w, in_range;

    // Free-running: keeps s_q tracking s while disabled so enabling never
    // sees a stale level as an edge.
    clks_alot_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i (sys_clk_i),
        .rst_i (sys_rst_i),
        .d_i   (sig_i),
        .q_o   (s)
    );

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            s_q <= 1'b0;
        end else begin
            s_q <= s;
        end
    end

    assign rise     = s & ~s_q;
    assign fall     = ~s & s_q;
    assign edge_w   = rise | fall;
    // cnt_q on the edge cycle is the completed half-period length.
    assign in_range = (cnt_q >= min_half_i) && (cnt_q <= max_half_i);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        good_d    = good_q;
        primed_d  = primed_q;
        high_d    = high_q;
        low_d     = low_q;
        valid_d   = 1'b0;
        glitch_d  = 1'b0;
        timeout_d = 1'b0;
        events_d  = '0;

        if (!enable_i) begin
            state_d  = ST_DISABLED;
            cnt_d    = '0;
            good_d   = '0;
            primed_d = 1'b0;
            high_d   = '0;
            low_d    = '0;
        end else if (state_q == ST_DISABLED) begin
            state_d  = ST_ACQUIRE;
            cnt_d    = '0;
            good_d   = '0;
            primed_d = 1'b0;
        end else begin
            events_d.rise     = rise;
            events_d.fall     = fall;
            events_d.any_edge = edge_w;

            if (edge_w) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (edge_w) begin
                if (!primed_q) begin
                    // First edge after enabling ends a partial half-period.
                    primed_d = 1'b1;
                end else begin
                    if (rise) begin
                        low_d = cnt_q;
                    end else begin
                        high_d = cnt_q;
                    end
                    if (state_q == ST_LOCKED && rise) begin
                        valid_d = 1'b1;
                    end
                    if (!in_range) begin
                        glitch_d = 1'b1;
                        good_d   = '0;
                        state_d  = ST_ACQUIRE;
                    end else if (state_q == ST_ACQUIRE) begin
                        if (good_q == GOOD_W'(LOCK_EDGES - 1)) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                            valid_d = rise;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end
                end
            end else if (cnt_q == max_half_i) begin
                // cnt becomes max+1 exactly once per stall; max is below
                // all-ones so saturation cannot retrigger this.
                timeout_d = 1'b1;
                good_d    = '0;
                state_d   = ST_ACQUIRE;
            end
        end

        period_d = {1'b0, high_d} + {1'b0, low_d};
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q   <= ST_DISABLED;
            cnt_q     <= '0;
            good_q    <= '0;
            primed_q  <= 1'b0;
            high_q    <= '0;
            low_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            glitch_q  <= 1'b0;
            timeout_q <= 1'b0;
            events_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            primed_q  <= primed_d;
            high_q    <= high_d;
            low_q     <= low_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            glitch_q  <= glitch_d;
            timeout_q <= timeout_d;
            events_q  <= events_d;
        end
    end

    always_comb begin
        status_o         = '0;
        status_o.locked  = (state_q == ST_LOCKED);
        status_o.glitch  = glitch_q;
        status_o.timeout = timeout_q;
    end

    assign events_o       = events_q;
    assign high_cycles_o  = high_q;
    assign low_cycles_o   = low_q;
    assign period_o       = period_q;
    assign period_valid_o = valid_q;

endmodule

// File: tb/tb_clks_alot_edge_monitor.sv
module tb_clks_alot_edge_monitor;
    import clks_alot_p::*;

    localparam int unsigned LOCK_EDGES = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sig;
    logic [15:0]   mn, mx;
    clock_events_s ev;
    clock_status_s st;
    logic [15:0]   hi, lo;
    logic [16:0]   per;
    logic          pv;

    always #5 clk = ~clk;

    clks_alot_edge_monitor #(
        .SYNC_STAGES (2),
        .CNT_W       (16),
        .LOCK_EDGES  (LOCK_EDGES)
    ) dut (
        .sys_clk_i      (clk),
        .sys_rst_i      (rst),
        .enable_i       (en),
        .sig_i          (sig),
        .min_half_i     (mn),
        .max_half_i     (mx),
        .events_o       (ev),
        .status_o       (st),
        .high_cycles_o  (hi),
        .low_cycles_o   (lo),
        .period_o       (per),
        .period_valid_o (pv)
    );

    typedef struct {
        bit rise;
        bit glitch;
        bit locked;
        bit valid;
        int high;
        int low;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   tcount = 0;
    bit   mon_en = 1'b0;

    bit   m_primed, m_locked;
    int   m_good, m_high, m_low;
    bit   cur_lvl;
    int   last_n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outcome of one sig edge, derived from the behavioural rules.
    task automatic push_edge(input bit is_rise, input int len);
        exp_t e;
        bit   inr;
        e.rise = is_rise; e.glitch = 0; e.valid = 0;
        if (!m_primed) begin
            m_primed = 1;
        end else begin
            if (is_rise) m_low = len; else m_high = len;
            inr = (len >= int'(mn)) && (len <= int'(mx));
            if (m_locked && is_rise) e.valid = 1;
            if (!inr) begin
                e.glitch = 1; m_good = 0; m_locked = 0;
            end else if (!m_locked) begin
                m_good++;
                if (m_good == LOCK_EDGES) begin
                    m_locked = 1; m_good = 0; e.valid = is_rise;
                end
            end
        end
        e.locked = m_locked; e.high = m_high; e.low = m_low;
        q.push_back(e);
    endtask

    // Drive sig_i at level lvl for n cycles (called at a negedge).
    task automatic half(input bit lvl, input int n);
        if (lvl != cur_lvl) begin
            push_edge(lvl, last_n);
            last_n = n;
        end else begin
            last_n += n;
        end
        cur_lvl = lvl;
        sig = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue", q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_events"}, ev, 0);
        chk({tag, "_status"}, st, 0);
        chk({tag, "_high"}, hi, 0);
        chk({tag, "_low"}, lo, 0);
        chk({tag, "_period"}, per, 0);
        chk({tag, "_pvalid"}, pv, 0);
    endtask

    // Scoreboard consumer: every event pulse pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (st.timeout) tcount++;
                if (ev.any_edge) begin
                    if (q.size() == 0) begin
                        chk("spurious_event", ev.any_edge, 0);
                    end else begin
                        e = q.pop_front();
                        chk("ev_rise", ev.rise, e.rise);
                        chk("ev_fall", ev.fall, !e.rise);
                        chk("glitch", st.glitch, e.glitch);
                        chk("locked", st.locked, e.locked);
                        chk("high_cycles", hi, e.high);
                        chk("low_cycles", lo, e.low);
                        chk("period", per, e.high + e.low);
                        chk("period_valid", pv, e.valid);
                    end
                end else begin
                    chk("stray_pulse", {st.glitch, pv}, 0);
                end
            end
        end
    end

    initial begin
        int t0;
        rst = 1; en = 0; sig = 0; mn = 3; mx = 5;
        cur_lvl = 0; last_n = 0;
        m_primed = 0; m_locked = 0; m_good = 0; m_high = 0; m_low = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 0;
        @(negedge clk);
        mon_en = 1;

        // Clean lock, 4/4 square wave, window 3..5
        en = 1;
        half(0, 6);
        repeat (4) begin half(1, 4); half(0, 4); end
        drain();
        chk("locked_clean", st.locked, 1);

        // One-cycle high glitch while locked, then relock
        half(1, 1);
        half(0, 4);
        half(1, 4); half(0, 4); half(1, 4); half(0, 4);
        half(1, 4);
        drain();
        chk("relocked_after_glitch", st.locked, 1);

        // Inverted window: every primed edge glitches, never locks
        mn = 6; mx = 5;
        repeat (3) begin half(0, 4); half(1, 4); end
        drain();
        chk("no_lock_min_gt_max", st.locked, 0);

        // Restore window and relock
        mn = 3; mx = 5;
        repeat (3) begin half(0, 4); half(1, 4); end
        drain();
        chk("relocked", st.locked, 1);

        // Stall low while locked: exactly one timeout
        t0 = tcount;
        half(0, 12);
        chk("locked_after_timeout", st.locked, 0);
        m_locked = 0; m_good = 0;
        half(1, 4);
        drain();
        chk("timeout_once", tcount - t0, 1);

        // Disable mid-stream with sig high
        en = 0;
        @(negedge clk);
        chk_all_zero("disabled");
        m_primed = 0; m_locked = 0; m_good = 0; m_high = 0; m_low = 0;
        repeat (4) @(negedge clk);

        // Re-enable while high; asymmetric 2/6 duty, window 2..6
        mn = 2; mx = 6;
        en = 1;
        half(1, 8);
        chk("no_event_on_enable", q.size(), 0);
        half(0, 6);
        half(1, 2);
        t0 = tcount;
        half(0, 6); half(1, 2); half(0, 6); half(1, 2); half(0, 6);
        drain();
        chk("asym_locked", st.locked, 1);
        chk("asym_high", hi, 2);
        chk("asym_low", lo, 6);
        chk("asym_period", per, 8);
        chk("edge_wins_at_max", tcount - t0, 0);

        // Asynchronous reset mid-lock
        mon_en = 0;
        #2 rst = 1;
        #1 chk_all_zero("mid_reset");
        q.delete();
        @(negedge clk);
        rst = 0;
        #1 chk("state_after_reset", 64'(dut.state_q), 64'(ST_DISABLED));
        chk_all_zero("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clks_alot_edge_monitor.md
# clks_alot_edge_monitor

Front end of the clock-recovery path. Synchronises one asynchronous clock-like input into the system domain and emits single-cycle rise/fall events. Measures high and low half-periods in system cycles and runs an acquire/lock state machine. Its event and status outputs feed `sir_clks_alot` recovery directly.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops on `sig_i`; minimum 2.
- `CNT_W`, 16: half-period counter and measurement width.
- `LOCK_EDGES`, 4: consecutive in-range half-periods required to lock; minimum 1.

- `sys_clk_i` in 1: system clock.
- `sys_rst_i` in 1: asynchronous, active-high reset.
- `enable_i` in 1: monitor enable; low forces DISABLED.
- `sig_i` in 1: asynchronous monitored signal.
- `min_half_i` in CNT_W: minimum legal half-period, in cycles.
- `max_half_i` in CNT_W: maximum legal half-period, in cycles; must be below all-ones.
- `events_o` out clks_alot_p::clock_events_s: `{rise, fall, edge}`, one-cycle pulses.
- `status_o` out clks_alot_p::clock_status_s: `{locked, glitch, timeout}`. `locked` is a level; `glitch` and `timeout` are pulses.
- `high_cycles_o` out CNT_W: last measured high half-period.
- `low_cycles_o` out CNT_W: last measured low half-period.
- `period_o` out CNT_W+1: `high_cycles_o + low_cycles_o`, zero-extended.
- `period_valid_o` out 1: pulse when `period_o` updates.

## Operation
- **Synchroniser and edge detect**
  - The synchroniser always runs, including while disabled, so enabling never creates a false edge.
  - `s` is the last synchroniser stage; `s_q` is `s` delayed one cycle.
  - Rise = `s & ~s_q`. Fall = `~s & s_q`.
- **Half-period counter `cnt`**
  - Set to 1 on an edge cycle.
  - Otherwise increments, saturating at all-ones.
  - Measured length = `cnt` on the edge cycle, before it is set to 1.
- **Captures**
  - Rise captures `low_cycles_o`; fall captures `high_cycles_o`.
  - A capture happens only when the state is not DISABLED and `primed` = 1.
- **`primed`**
  - Cleared on entering ACQUIRE from DISABLED.
  - Set by the first edge afterwards. That edge's measurement is partial and is discarded: no capture, no range check.
- **In-range test:** `min_half_i <= len <= max_half_i`, unsigned.
- **FSM states:** DISABLED, ACQUIRE, LOCKED.
  - DISABLED: `cnt`, `good`, captures and outputs are zero. Go to ACQUIRE when `enable_i` = 1.
  - ACQUIRE:
    - In-range edge: `good++`. On reaching `LOCK_EDGES`, go to LOCKED and clear `good`.
    - Out-of-range edge: pulse `glitch`, `good` = 0.
  - LOCKED:
    - Out-of-range edge: pulse `glitch`, go to ACQUIRE with `good` = 0 and `primed` kept at 1.
  - Any state: `enable_i` = 0 goes to DISABLED next cycle.
- **Timeout**
  - Fires in ACQUIRE or LOCKED on a non-edge cycle where `cnt` becomes `max_half_i + 1`.
  - It pulses exactly once per stall.
  - In ACQUIRE, `good` = 0. In LOCKED, go to ACQUIRE.
- **Period output:** `period_valid_o` pulses on a rise that captures while LOCKED, or on the rise that causes the lock.
- **Config changes:** `min_half_i` / `max_half_i` may change at any time and apply on the next comparison.
- **Boundary cases**
  - `min_half_i > max_half_i`: never locks; every primed edge glitches.
  - Edge on the timeout cycle: the edge wins and no timeout fires.
  - Counter saturation: no wrap.
  - Reset mid-operation: everything returns to reset values immediately.

## Timing
- Reset values: all outputs 0; state DISABLED; `cnt`, `good`, `primed`, captures all 0. The synchroniser flops and `s_q` also reset to 0.
- Latency, `sig_i` toggle to `events_o` pulse: `SYNC_STAGES + 1` cycles, plus up to 1 cycle of async uncertainty.
- `status_o.glitch`, `high_cycles_o`, `low_cycles_o`, `period_o` and `period_valid_o` are registered. They update in the same cycle as the corresponding `events_o` pulse.
- `locked` rises in the same cycle as the qualifying edge event and falls in the same cycle as the glitch or timeout pulse.
- `events_o` is gated to zero while DISABLED.
- Minimum resolvable half-period: 1 cycle (len = 1).

## Structure
- `clks_alot_p` holds:
  - `clock_events_s` `{rise, fall, edge}`
  - `clock_status_s` `{locked, glitch, timeout}`
  - an FSM state enum `edge_mon_state_e`
- Sub-module `clks_alot_sync`: parameterised N-flop synchroniser with async active-high reset. It is reused elsewhere in clks_alot.
- All other logic lives inline: edge detect, counter, range compare, FSM.
- Target size: about 200 lines of RTL.

## Test plan
- **Reset:** assert `sys_rst_i` mid-lock → all outputs 0 the same cycle; after release, state is DISABLED.
- **Clean lock:** `enable_i` = 1; square wave 4 high / 4 low; min = 3, max = 5; `LOCK_EDGES` = 4.
  - First edge discarded.
  - `locked` at the 5th edge.
  - `high_cycles_o` = `low_cycles_o` = 4.
  - `period_o` = 8 with `period_valid_o` on rises.
- **Glitch while locked:** insert a 1-cycle high pulse → `glitch` pulse, `locked` drops, relock after 4 good half-periods.
- **Timeout:** hold `sig_i` low while locked with max = 5 → `timeout` pulse once when `cnt` reaches 6, `locked` = 0, no repeat pulses.
- **Asymmetric duty:** 2 high / 6 low; min = 2, max = 6 → `high_cycles_o` = 2, `low_cycles_o` = 6, `period_o` = 8, locks.
- **Enable toggling:** disable mid-stream → outputs zero next cycle. Re-enable while `sig_i` is high → no spurious `events_o`; first edge not captured.
